// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue buffer: MIPS opcode/funct
// encodings, ALU operation codes, FIFO occupancy states and the decoded entry.
package alu_issue_pkg;

    // Major opcodes (instr[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // ALU operation codes presented on op
    localparam logic [5:0] ALU_NOP  = 6'b000000;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_SRA  = 6'b000011;
    localparam logic [5:0] ALU_SRAV = 6'b000111;
    localparam logic [5:0] ALU_SLT  = 6'b101010;

    // FIFO occupancy; the encoding doubles as the entry count
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // One decoded, buffered instruction
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [5:0]  sa;
        logic [4:0]  dest;
        logic        wen;
        logic        illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_if.sv
// Issue-side bundle: the upstream offer (instr plus register reads) and the
// downstream ALU presentation. Both sides use valid/ready: a transfer happens
// in a cycle where valid and ready are both high at the rising edge; the
// producer keeps its payload stable while valid is high and ready is low.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [5:0]  sa;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;

    // The issue block itself
    modport slave (
        input  in_valid, instr, rs_data, rt_data, out_ready,
        output in_ready, out_valid, a, b, op, sa, dest, wen, illegal
    );

    // The surrounding pipeline (register read stage and ALU)
    modport master (
        output in_valid, instr, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, a, b, op, sa, dest, wen, illegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode for the ALU subset: produces operands, op code,
// shift amount and writeback fields; anything unsupported is flagged illegal
// with all payload zeroed.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  rs_data,
    input  logic [31:0]  rt_data,
    output issue_entry_t entry
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // The rs index is not needed here: its value already arrives as rs_data.
    logic unused_rs_index;
    assign unused_rs_index = ^instr[25:21];

    // Decode the instruction into a buffered entry
    always_comb begin
        entry         = '0;
        entry.illegal = 1'b1;
        if (opcode == OPC_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU: begin entry.op = ALU_ADD; entry.illegal = 1'b0; end
                FN_SUB, FN_SUBU: begin entry.op = ALU_SUB; entry.illegal = 1'b0; end
                FN_SLT:          begin entry.op = ALU_SLT; entry.illegal = 1'b0; end
                FN_SRA: begin
                    entry.op      = ALU_SRA;
                    entry.sa      = {1'b0, instr[10:6]};
                    entry.illegal = 1'b0;
                end
                FN_SRAV: begin
                    entry.op      = ALU_SRAV;
                    entry.sa      = {1'b0, rs_data[4:0]};
                    entry.illegal = 1'b0;
                end
                default: ;
            endcase
            if (!entry.illegal) begin
                entry.a    = rs_data;
                entry.b    = rt_data;
                entry.dest = instr[15:11];
            end
        end else begin
            case (opcode)
                OPC_ADDI, OPC_ADDIU: begin entry.op = ALU_ADD; entry.illegal = 1'b0; end
                OPC_SLTI:            begin entry.op = ALU_SLT; entry.illegal = 1'b0; end
                default: ;
            endcase
            if (!entry.illegal) begin
                entry.a    = rs_data;
                entry.b    = {{16{instr[15]}}, instr[15:0]};
                entry.dest = instr[20:16];
            end
        end
        // Writes to $0 are architecturally discarded, so never request them
        entry.wen = !entry.illegal && (entry.dest != 5'd0);
    end

endmodule

// File: rtl/alu_issue.sv
// Two-entry issue buffer between register read and the ALU. Incoming
// instructions are decoded on the way in; the head entry drives the ALU
// operands directly from a register, so outputs are glitch-free and zero
// whenever nothing is presented.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.slave  bus,
    output logic [1:0]  state_dbg
);

    fifo_state_e  state_q, state_d;
    issue_entry_t head_q, head_d;
    issue_entry_t tail_q, tail_d;
    issue_entry_t dec_entry;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    alu_issue_decode u_decode (
        .instr   (bus.instr),
        .rs_data (bus.rs_data),
        .rt_data (bus.rt_data),
        .entry   (dec_entry)
    );

    // in_ready depends on registered state only, so no out_ready->in_ready path
    assign in_ready  = (state_q != FIFO_FULL);
    assign out_valid = (state_q != FIFO_EMPTY);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // Next-state and storage update: head is always the presented entry
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = FIFO_EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                FIFO_EMPTY: begin
                    if (push) begin
                        state_d = FIFO_ONE;
                        head_d  = dec_entry;
                    end
                end
                FIFO_ONE: begin
                    if (push && pop) begin
                        head_d = dec_entry;
                    end else if (push) begin
                        state_d = FIFO_FULL;
                        tail_d  = dec_entry;
                    end else if (pop) begin
                        state_d = FIFO_EMPTY;
                        head_d  = '0;
                    end
                end
                FIFO_FULL: begin
                    if (pop) begin
                        state_d = FIFO_ONE;
                        head_d  = tail_q;
                        tail_d  = '0;
                    end
                end
                default: begin
                    state_d = FIFO_EMPTY;
                    head_d  = '0;
                    tail_d  = '0;
                end
            endcase
        end
    end

    // State and entry registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIFO_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.a         = head_q.a;
    assign bus.b         = head_q.b;
    assign bus.op        = head_q.op;
    assign bus.sa        = head_q.sa;
    assign bus.dest      = head_q.dest;
    assign bus.wen       = head_q.wen;
    assign bus.illegal   = head_q.illegal;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios followed by random traffic, all
// checked against a queue-based model of a two-deep FIFO of decoded entries.
module tb_alu_issue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [5:0]  sa;
        logic [4:0]  dest;
        logic        wen;
        logic        illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    exp_t model_q[$];

    alu_issue_if bus ();

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock: 10 time-unit period
    always #5 clk = ~clk;

    // Reference decode straight from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t r;
        int opc;
        int fn;
        r = '0;
        r.illegal = 1'b1;
        opc = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        if (opc == 0) begin
            case (fn)
                32, 33: begin r.op = 6'd32; r.illegal = 1'b0; end
                34, 35: begin r.op = 6'd34; r.illegal = 1'b0; end
                42:     begin r.op = 6'd42; r.illegal = 1'b0; end
                3:      begin r.op = 6'd3;  r.sa = {1'b0, ins[10:6]}; r.illegal = 1'b0; end
                7:      begin r.op = 6'd7;  r.sa = {1'b0, rs[4:0]};   r.illegal = 1'b0; end
                default: ;
            endcase
            if (!r.illegal) begin
                r.a = rs;
                r.b = rt;
                r.dest = ins[15:11];
            end
        end else if (opc == 8 || opc == 9 || opc == 10) begin
            r.op = (opc == 10) ? 6'd42 : 6'd32;
            r.illegal = 1'b0;
            r.a = rs;
            r.b = 32'($signed(ins[15:0]));
            r.dest = ins[20:16];
        end
        r.wen = !r.illegal && (r.dest != 5'd0);
        return r;
    endfunction

    // Random instruction mix weighted towards legal encodings
    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0] f;
        int k;
        r = $urandom();
        k = $urandom_range(0, 9);
        if (k <= 5) begin
            case ($urandom_range(0, 6))
                0: f = 6'd32;
                1: f = 6'd33;
                2: f = 6'd34;
                3: f = 6'd35;
                4: f = 6'd3;
                5: f = 6'd7;
                default: f = 6'd42;
            endcase
            return {6'd0, r[25:6], f};
        end else if (k <= 7) begin
            f = 6'($urandom_range(8, 10));
            return {f, r[25:0]};
        end else if (k == 8) begin
            return {6'd0, r[25:0]};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with what the model says is presented now
    task automatic check_all(input string tag);
        exp_t e;
        logic nonempty;
        e = '0;
        nonempty = (model_q.size() != 0);
        if (nonempty) e = model_q[0];
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(nonempty));
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(model_q.size() < 2));
        chk({tag, ".state"},     32'(state_dbg),     32'(model_q.size()));
        chk({tag, ".a"},         bus.a,              e.a);
        chk({tag, ".b"},         bus.b,              e.b);
        chk({tag, ".op"},        32'(bus.op),        32'(e.op));
        chk({tag, ".sa"},        32'(bus.sa),        32'(e.sa));
        chk({tag, ".dest"},      32'(bus.dest),      32'(e.dest));
        chk({tag, ".wen"},       32'(bus.wen),       32'(e.wen));
        chk({tag, ".illegal"},   32'(bus.illegal),   32'(e.illegal));
    endtask

    // Driver: apply one cycle of inputs, advance the model, check at negedge
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic ordy, input logic fl);
        int sz;
        logic pu;
        logic po;
        exp_t dropped;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.out_ready = ordy;
        flush         = fl;
        @(posedge clk);
        sz = model_q.size();
        pu = v && (sz < 2);
        po = (sz > 0) && ordy;
        if (fl) begin
            model_q.delete();
        end else begin
            if (po) dropped = model_q.pop_front();
            if (pu) model_q.push_back(ref_decode(ins, rs, rt));
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.rs_data   = '0;
        bus.rt_data   = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // add $10,$8,$9 with rs=5 rt=7: presented the very next cycle
        step("add", 1'b1, 32'h01095020, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add.out_valid", 32'(bus.out_valid), 32'd1);
        chk("add.op",        32'(bus.op),        32'h20);
        chk("add.a",         bus.a,              32'd5);
        chk("add.b",         bus.b,              32'd7);
        chk("add.dest",      32'(bus.dest),      32'd10);
        chk("add.wen",       32'(bus.wen),       32'd1);
        step("add_drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);

        // addi with negative immediate, then sra pushed while addi is popped
        step("addi", 1'b1, 32'h2108FFFF, 32'd3, 32'd0, 1'b1, 1'b0);
        chk("addi.op",   32'(bus.op),   32'h20);
        chk("addi.b",    bus.b,         32'hFFFFFFFF);
        chk("addi.dest", 32'(bus.dest), 32'd8);
        step("sra", 1'b1, 32'h00084083, 32'd0, 32'h80000000, 1'b1, 1'b0);
        chk("sra.op", 32'(bus.op), 32'h03);
        chk("sra.sa", 32'(bus.sa), 32'd2);
        step("sra_drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Illegal opcode, then add targeting $0
        step("illegal", 1'b1, 32'hFC000000, 32'd9, 32'd9, 1'b0, 1'b0);
        chk("illegal.illegal", 32'(bus.illegal), 32'd1);
        chk("illegal.op",      32'(bus.op),      32'd0);
        chk("illegal.wen",     32'(bus.wen),     32'd0);
        step("rd0", 1'b1, 32'h01090020, 32'd1, 32'd2, 1'b1, 1'b0);
        step("rd0_head", 1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("rd0.wen",     32'(bus.wen),     32'd0);
        chk("rd0.illegal", 32'(bus.illegal), 32'd0);
        step("rd0_drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Back-pressure: three back-to-back pushes, the third held off
        step("bp1", 1'b1, 32'h01090020 | (32'd1 << 11), 32'd11, 32'd1, 1'b0, 1'b0);
        step("bp2", 1'b1, 32'h01090020 | (32'd2 << 11), 32'd12, 32'd2, 1'b0, 1'b0);
        chk("bp2.in_ready", 32'(bus.in_ready), 32'd0);
        step("bp3_held", 1'b1, 32'h01090020 | (32'd3 << 11), 32'd13, 32'd3, 1'b0, 1'b0);
        chk("bp3.head_dest", 32'(bus.dest), 32'd1);
        step("bp_pop1", 1'b1, 32'h01090020 | (32'd3 << 11), 32'd13, 32'd3, 1'b1, 1'b0);
        chk("bp_pop1.dest", 32'(bus.dest), 32'd2);
        step("bp_pop2", 1'b1, 32'h01090020 | (32'd3 << 11), 32'd13, 32'd3, 1'b1, 1'b0);
        chk("bp_pop2.dest", 32'(bus.dest), 32'd3);
        step("bp_pop3", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        chk("bp_pop3.out_valid", 32'(bus.out_valid), 32'd0);

        // Flush while full, with a push offered in the same cycle
        step("fl1", 1'b1, 32'h01095020, 32'd1, 32'd1, 1'b0, 1'b0);
        step("fl2", 1'b1, 32'h01095020, 32'd2, 32'd2, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h01095020, 32'd3, 32'd3, 1'b0, 1'b1);
        chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush.in_ready",  32'(bus.in_ready),  32'd1);

        // Random traffic with an asynchronous reset pulse part-way through
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                step("pre_rst1", 1'b1, rand_instr(), $urandom(), $urandom(), 1'b0, 1'b0);
                step("pre_rst2", 1'b1, rand_instr(), $urandom(), $urandom(), 1'b0, 1'b0);
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
                chk("async_rst.in_ready",  32'(bus.in_ready),  32'd1);
                chk("async_rst.a",         bus.a,              32'd0);
                chk("async_rst.b",         bus.b,              32'd0);
                chk("async_rst.op",        32'(bus.op),        32'd0);
                chk("async_rst.dest",      32'(bus.dest),      32'd0);
                model_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                check_all("rst_release");
            end
            step("rand", $urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                 $urandom(), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        step("final_drain1", 1'b0, '0, '0, '0, 1'b1, 1'b0);
        step("final_drain2", 1'b0, '0, '0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
